// File: rtl/frac_sad_accum.sv
// ============================================================================
//  Module      : frac_sad_accum
//  Description : Sequential SAD engine for fractional motion estimation.
//                Accumulates per-position line SADs over BLK_H lines, then
//                searches the N_POS totals for the minimum (ties -> lower idx)
//                and returns index + SAD over a valid/ready handshake.
//                Optional feature macro: FRAC_SAD_ALL_OUT_EN (adds out_sad_all).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_sad_accum #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 6,
  parameter int N_POS = 25,
  parameter int BLK_H = 6,
  parameter int SAD_W = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic [N_POS*N_PIX*PIX_W-1:0]   diff_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(N_POS)-1:0]       out_best_idx,
  output logic [SAD_W-1:0]               out_best_sad,
  output logic                           drop_pulse
`ifdef FRAC_SAD_ALL_OUT_EN
  ,
  output logic [N_POS*SAD_W-1:0]         out_sad_all
`endif
);

  localparam int LSUM_W = PIX_W + $clog2(N_PIX);
  // One extra bit above the wider operand so the saturating add never wraps
  localparam int EXT_W  = ((SAD_W > LSUM_W) ? SAD_W : LSUM_W) + 1;
  localparam int IDX_W  = $clog2(N_POS);
  localparam int LC_W   = $clog2(BLK_H + 1);

  localparam logic [EXT_W-1:0] c_SAD_MAX = {{(EXT_W-SAD_W){1'b0}}, {SAD_W{1'b1}}};

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ACCUM  = 3'd1;
  localparam logic [2:0] c_DRAIN  = 3'd2;
  localparam logic [2:0] c_SEARCH = 3'd3;
  localparam logic [2:0] c_OUT    = 3'd4;

  logic [2:0]        r_state;
  logic [LC_W-1:0]   r_line_cnt;
  logic              r_drain;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_best_idx;
  logic [SAD_W-1:0]  r_best_sad;
  logic              r_drop;

  logic              r_s1_valid;
  logic              r_s1_clear;
  logic [LSUM_W-1:0] r_line_sum [N_POS];
  logic [SAD_W-1:0]  r_acc      [N_POS];

  logic [LSUM_W-1:0] w_line_sum [N_POS];
  logic [EXT_W-1:0]  w_acc_sum  [N_POS];
  logic [SAD_W-1:0]  w_acc_next [N_POS];
  logic              w_accept;
  logic              w_take;
  logic [SAD_W-1:0]  w_cand;

  assign in_ready = (r_state == c_IDLE) || (r_state == c_ACCUM);
  assign w_accept = in_valid && in_ready;
  // A beat enters the datapath unless it is an orphan line seen in IDLE
  assign w_take   = w_accept && ((r_state != c_IDLE) || in_first);
  assign w_cand   = r_acc[r_idx];

  // Per-position line sum of N_PIX abs diffs
  always_comb begin
    for (int p = 0; p < N_POS; p++) begin
      w_line_sum[p] = '0;
      for (int k = 0; k < N_PIX; k++) begin
        w_line_sum[p] = w_line_sum[p] + LSUM_W'(diff_in[(p*N_PIX+k)*PIX_W +: PIX_W]);
      end
    end
  end

  // Saturating accumulate; a first-line beat restarts from zero
  always_comb begin
    for (int p = 0; p < N_POS; p++) begin
      w_acc_sum[p]  = (r_s1_clear ? '0 : EXT_W'(r_acc[p])) + EXT_W'(r_line_sum[p]);
      w_acc_next[p] = (w_acc_sum[p] > c_SAD_MAX) ? {SAD_W{1'b1}} : w_acc_sum[p][SAD_W-1:0];
    end
  end

  // Stage 1: register line sums of accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_clear <= 1'b0;
      for (int p = 0; p < N_POS; p++) r_line_sum[p] <= '0;
    end else begin
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_clear <= in_first;
        r_line_sum <= w_line_sum;
      end
    end
  end

  // Stage 2: update accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_POS; p++) r_acc[p] <= '0;
    end else if (r_s1_valid) begin
      r_acc <= w_acc_next;
    end
  end

  // Block control FSM, minimum search and drop pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_line_cnt <= '0;
      r_drain    <= 1'b0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_sad <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= (r_state == c_IDLE) && in_valid && !in_first;
      case (r_state)
        c_IDLE, c_ACCUM: begin
          if (w_take) begin
            if (in_first) begin
              r_line_cnt <= LC_W'(1);
              if (BLK_H == 1) begin
                r_state <= c_DRAIN;
                r_drain <= 1'b0;
              end else begin
                r_state <= c_ACCUM;
              end
            end else if (r_line_cnt == LC_W'(BLK_H - 1)) begin
              r_state <= c_DRAIN;
              r_drain <= 1'b0;
            end else begin
              r_line_cnt <= r_line_cnt + LC_W'(1);
            end
          end
        end
        c_DRAIN: begin
          // Two cycles lets the last line clear both pipeline stages
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= c_SEARCH;
            r_idx   <= '0;
          end
        end
        c_SEARCH: begin
          if ((r_idx == '0) || (w_cand < r_best_sad)) begin
            r_best_idx <= r_idx;
            r_best_sad <= w_cand;
          end
          if (r_idx == IDX_W'(N_POS - 1)) begin
            r_state <= c_OUT;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_OUT: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign out_valid    = (r_state == c_OUT);
  assign out_best_idx = r_best_idx;
  assign out_best_sad = r_best_sad;
  assign drop_pulse   = r_drop;

`ifdef FRAC_SAD_ALL_OUT_EN
  for (genvar p = 0; p < N_POS; p++) begin : g_sad_all
    assign out_sad_all[p*SAD_W +: SAD_W] = r_acc[p];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_frac_sad_accum.sv
// ============================================================================
//  Module      : tb_frac_sad_accum
//  Description : Scoreboard bench for frac_sad_accum. Two instances share the
//                stimulus: default widths, and SAD_W=10 for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frac_sad_accum;

  localparam int PIX_W   = 8;
  localparam int N_PIX   = 6;
  localparam int N_POS   = 25;
  localparam int BLK_H   = 6;
  localparam int SAD_W   = 14;
  localparam int SAD_W_B = 10;
  localparam int IDX_W   = $clog2(N_POS);

  typedef struct { int idx; int sad; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst, in_valid, in_first, out_ready;
  logic [N_POS*N_PIX*PIX_W-1:0] diff_in;
  logic                         in_ready_a, out_valid_a, drop_a;
  logic [IDX_W-1:0]             idx_a;
  logic [SAD_W-1:0]             sad_a;
  logic                         in_ready_b, out_valid_b, drop_b;
  logic [IDX_W-1:0]             idx_b;
  logic [SAD_W_B-1:0]           sad_b;
`ifdef FRAC_SAD_ALL_OUT_EN
  logic [N_POS*SAD_W-1:0]       all_a;
  logic [N_POS*SAD_W_B-1:0]     all_b;
`endif

  frac_sad_accum #(.PIX_W(PIX_W), .N_PIX(N_PIX), .N_POS(N_POS), .BLK_H(BLK_H), .SAD_W(SAD_W)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_first(in_first),
    .diff_in(diff_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_best_idx(idx_a), .out_best_sad(sad_a), .drop_pulse(drop_a)
`ifdef FRAC_SAD_ALL_OUT_EN
    , .out_sad_all(all_a)
`endif
  );

  frac_sad_accum #(.PIX_W(PIX_W), .N_PIX(N_PIX), .N_POS(N_POS), .BLK_H(BLK_H), .SAD_W(SAD_W_B)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_first(in_first),
    .diff_in(diff_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_best_idx(idx_b), .out_best_sad(sad_b), .drop_pulse(drop_b)
`ifdef FRAC_SAD_ALL_OUT_EN
    , .out_sad_all(all_b)
`endif
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   m_acc_a [N_POS];
  int   m_acc_b [N_POS];
  int   m_cnt    = 0;
  bit   m_active = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model of one accepted beat; pushes expected result on a block's last line
  task automatic model_beat(input bit first);
    int ls, max_a, max_b, ba, bb;
    exp_t e;
    if (!m_active && !first) return;
    max_a = (1 << SAD_W) - 1;
    max_b = (1 << SAD_W_B) - 1;
    for (int p = 0; p < N_POS; p++) begin
      ls = 0;
      for (int k = 0; k < N_PIX; k++) ls += int'(diff_in[(p*N_PIX+k)*PIX_W +: PIX_W]);
      m_acc_a[p] = (first ? 0 : m_acc_a[p]) + ls;
      m_acc_b[p] = (first ? 0 : m_acc_b[p]) + ls;
      if (m_acc_a[p] > max_a) m_acc_a[p] = max_a;
      if (m_acc_b[p] > max_b) m_acc_b[p] = max_b;
    end
    m_cnt    = first ? 1 : m_cnt + 1;
    m_active = 1'b1;
    if (m_cnt == BLK_H) begin
      ba = 0; bb = 0;
      for (int p = 1; p < N_POS; p++) begin
        if (m_acc_a[p] < m_acc_a[ba]) ba = p;
        if (m_acc_b[p] < m_acc_b[bb]) bb = p;
      end
      e.idx = ba; e.sad = m_acc_a[ba]; q_a.push_back(e);
      e.idx = bb; e.sad = m_acc_b[bb]; q_b.push_back(e);
      m_active = 1'b0;
      m_cnt    = 0;
    end
  endtask

  // mode 0: all diffs = v except position sp = spv; mode 1: random 0..v
  task automatic drive_beat(input bit first, input int mode, input int v, input int sp, input int spv);
    int n = 0;
    while (!in_ready_a && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", in_ready_a, 1'b1);
    for (int p = 0; p < N_POS; p++)
      for (int k = 0; k < N_PIX; k++)
        diff_in[(p*N_PIX+k)*PIX_W +: PIX_W] =
          PIX_W'((mode == 1) ? $urandom_range(0, v) : ((p == sp) ? spv : v));
    in_valid = 1'b1;
    in_first = first;
    model_beat(first);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_block(input int mode, input int v, input int sp, input int spv);
    for (int l = 0; l < BLK_H; l++) drive_beat(l == 0, mode, v, sp, spv);
  endtask

  // Waits for out_valid; returns edges elapsed since the call
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid_a && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("out_valid_rise", out_valid_a, 1'b1);
  endtask

  // Scoreboard: compare on every consumed result
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a && out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_out", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_best_idx", 32'(idx_a), e.idx);
        chk("a_best_sad", 32'(sad_a), e.sad);
      end
    end
    if (out_valid_b && out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_best_idx", 32'(idx_b), e.idx);
        chk("b_best_sad", 32'(sad_b), e.sad);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    logic [IDX_W-1:0] h_idx;
    logic [SAD_W-1:0] h_sad;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1; diff_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready_a,  1'b1);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_best_idx",  32'(idx_a),  0);
    chk("rst_best_sad",  32'(sad_a),  0);
    chk("rst_drop",      drop_a,      1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single zero position, plus latency from last accepted line
    send_block(0, 1, 7, 0);
    wait_out(n);
    chk("t1_latency", n, 27);
    @(posedge clk); #1;

    // All equal: tie keeps index 0, sad 3*6*6
    send_block(0, 3, -1, 0);
    wait_out(n);
    @(posedge clk); #1;

    // Restart on line 3 of a block
    for (int l = 0; l < 3; l++) drive_beat(l == 0, 1, 60, -1, 0);
    send_block(1, 40, -1, 0);
    wait_out(n);
    @(posedge clk); #1;

    // All 255: instance B saturates at 1023
    send_block(0, 255, -1, 0);
    wait_out(n);
    @(posedge clk); #1;

    // Random blocks
    for (int b = 0; b < 2; b++) begin
      send_block(1, 30, -1, 0);
      wait_out(n);
      @(posedge clk); #1;
    end

    // Back-pressure on the result
    out_ready = 1'b0;
    send_block(1, 50, -1, 0);
    wait_out(n);
    h_idx = idx_a;
    h_sad = sad_a;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid_a, 1'b1);
      chk("hold_in_ready",  in_ready_a,  1'b0);
      chk("hold_idx",       32'(idx_a),  32'(h_idx));
      chk("hold_sad",       32'(sad_a),  32'(h_sad));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", out_valid_a, 1'b0);
    chk("release_in_ready",  in_ready_a,  1'b1);

    // Orphan beat in IDLE is dropped
    in_valid = 1'b1; in_first = 1'b0;
    model_beat(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("drop_pulse_hi",  drop_a,      1'b1);
    chk("drop_in_ready",  in_ready_a,  1'b1);
    chk("drop_out_valid", out_valid_a, 1'b0);
    @(posedge clk); #1;
    chk("drop_pulse_lo",  drop_a,      1'b0);

    // Reset in the middle of the search
    send_block(0, 2, -1, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete(); q_b.delete();
    m_active = 1'b0; m_cnt = 0;
    chk("abort_out_valid", out_valid_a, 1'b0);
    chk("abort_in_ready",  in_ready_a,  1'b1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid_a) cnt++;
    end
    chk("abort_no_result", cnt, 0);

    // Recovery after abort
    send_block(0, 5, 20, 1);
    wait_out(n);
    @(posedge clk); #1;

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
